// File: rtl/mem_access_pkg.sv
// Shared instruction-type, access-size and exception-cause definitions for the
// memory-access stage.
package bexkat1Def;

    localparam logic [3:0] T_ALU   = 4'h1;
    localparam logic [3:0] T_LOAD  = 4'h7;
    localparam logic [3:0] T_STORE = 4'h8;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2,
        SZ_RSVD = 2'd3
    } size_t;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'd0,
        EXC_MISALIGN = 2'd1,
        EXC_BUS      = 2'd2,
        EXC_TIMEOUT  = 2'd3
    } cause_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUS  = 1'b1
    } state_t;

    // Reserved size behaves as a word access.
    function automatic logic misaligned(input size_t sz, input logic [1:0] adr_lo);
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return adr_lo[0];
            default: return adr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Wishbone classic bus bundle between the memory-access stage and memory.
interface mem_access_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;

    modport master (output cyc, stb, we, adr, sel, dat_w, input dat_r, ack, err);
    modport slave  (input cyc, stb, we, adr, sel, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/mem_access_lane.sv
// Big-endian byte-lane steering: select mask, store replication, load extraction.
module mem_lane
    import bexkat1Def::*;
(
    input  size_t       size,
    input  logic [1:0]  adr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_raw,
    output logic [3:0]  sel,
    output logic [31:0] st_lanes,
    output logic [31:0] ld_data
);
    always_comb begin
        sel      = 4'b1111;
        st_lanes = st_data;
        ld_data  = ld_raw;
        case (size)
            SZ_HALF: begin
                sel      = adr_lo[1] ? 4'b0011 : 4'b1100;
                st_lanes = {2{st_data[15:0]}};
                ld_data  = {16'h0, adr_lo[1] ? ld_raw[15:0] : ld_raw[31:16]};
            end
            SZ_BYTE: begin
                sel      = 4'b1000 >> adr_lo;
                st_lanes = {4{st_data[7:0]}};
                case (adr_lo)
                    2'd0:    ld_data = {24'h0, ld_raw[31:24]};
                    2'd1:    ld_data = {24'h0, ld_raw[23:16]};
                    2'd2:    ld_data = {24'h0, ld_raw[15:8]};
                    default: ld_data = {24'h0, ld_raw[7:0]};
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes non-memory instructions through and runs
// one Wishbone classic cycle per load/store, stalling upstream while it waits.
module mem_access
    import bexkat1Def::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [63:0]  ir_i,
    input  logic [31:0]  pc_i,
    input  logic [31:0]  result_i,
    input  logic [31:0]  reg_data1_i,
    input  logic [1:0]   reg_write_i,
    output logic         stall_o,
    mem_access_if.master bus,
    output logic [31:0]  result_o,
    output logic [1:0]   reg_write_o,
    output logic [63:0]  ir_o,
    output logic [31:0]  pc_o,
    output logic         exc_o,
    output logic [1:0]   exc_cause_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state, state_nx;
    logic [CW-1:0] count;
    logic [3:0]    ir_type;
    size_t         size;
    logic          is_load, is_store, mem_op, bad_align, timeout, bus_done;
    logic          do_pass, do_issue, do_wb, do_count;
    cause_t        cause;
    logic [3:0]    lane_sel;
    logic [31:0]   lane_st, lane_ld;

    assign ir_type   = ir_i[31:28];
    assign size      = size_t'(ir_i[25:24]);
    assign is_load   = (ir_type == T_LOAD);
    assign is_store  = (ir_type == T_STORE);
    assign mem_op    = is_load | is_store;
    assign bad_align = misaligned(size, result_i[1:0]);
    assign timeout   = (count == CW'(TIMEOUT));
    assign bus_done  = bus.ack | bus.err | timeout;

    // Upstream holds its inputs while stalled, so lanes can always use them directly.
    mem_lane u_lane (
        .size     (size),
        .adr_lo   (result_i[1:0]),
        .st_data  (reg_data1_i),
        .ld_raw   (bus.dat_r),
        .sel      (lane_sel),
        .st_lanes (lane_st),
        .ld_data  (lane_ld)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (mem_op && !bad_align) state_nx = S_BUS;
            S_BUS:   if (bus_done) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        stall_o  = 1'b0;
        do_pass  = 1'b0;
        do_issue = 1'b0;
        do_wb    = 1'b0;
        do_count = 1'b0;
        cause    = EXC_NONE;
        case (state)
            S_IDLE: begin
                if (!mem_op) do_pass = 1'b1;
                else if (bad_align) cause = EXC_MISALIGN;
                else begin
                    stall_o  = 1'b1;
                    do_issue = 1'b1;
                end
            end
            S_BUS: begin
                stall_o = !bus_done;
                if (bus.err)      cause = EXC_BUS;
                else if (bus.ack) do_wb = 1'b1;
                else if (timeout) cause = EXC_TIMEOUT;
                else              do_count = 1'b1;
            end
            default: ;
        endcase
        if (rst_i) stall_o = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.cyc     <= 1'b0;
            bus.stb     <= 1'b0;
            bus.we      <= 1'b0;
            bus.adr     <= '0;
            bus.sel     <= '0;
            bus.dat_w   <= '0;
            count       <= '0;
            result_o    <= '0;
            reg_write_o <= '0;
            ir_o        <= '0;
            pc_o        <= '0;
            exc_o       <= 1'b0;
            exc_cause_o <= '0;
        end else begin
            exc_o       <= (cause != EXC_NONE);
            exc_cause_o <= cause;
            ir_o        <= '0;
            pc_o        <= '0;
            result_o    <= '0;
            reg_write_o <= '0;
            if (do_pass) begin
                ir_o        <= ir_i;
                pc_o        <= pc_i;
                result_o    <= result_i;
                reg_write_o <= reg_write_i;
            end else if (do_wb) begin
                ir_o        <= ir_i;
                pc_o        <= pc_i;
                result_o    <= is_load ? lane_ld : result_i;
                reg_write_o <= is_load ? 2'b11 : 2'b00;
            end
            if (do_issue) begin
                bus.cyc   <= 1'b1;
                bus.stb   <= 1'b1;
                bus.we    <= is_store;
                bus.adr   <= result_i;
                bus.sel   <= lane_sel;
                bus.dat_w <= lane_st;
                count     <= '0;
            end else if (state == S_BUS && bus_done) begin
                bus.cyc <= 1'b0;
                bus.stb <= 1'b0;
                bus.we  <= 1'b0;
                count   <= '0;
            end else if (do_count) begin
                count <= count + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: fixed vector table, reset sequences and randomized ops
// checked against an arithmetic byte-lane/exception model.
module tb_mem_access;
    import bexkat1Def::*;

    localparam int TMO = 255;

    typedef struct {
        logic [3:0]  typ;
        logic [1:0]  sz;
        logic [1:0]  rwi;
        logic [31:0] adr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          waits;
        int          kind;     // 0 ack, 1 err, 2 silent (timeout), 3 ack+err
        logic [3:0]  e_sel;
        logic [31:0] e_dat;
        logic [31:0] e_res;
        logic [1:0]  e_rw;
        logic [1:0]  e_cause;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [63:0] ir_i;
    logic [31:0] pc_i, result_i, reg_data1_i;
    logic [1:0]  reg_write_i;
    logic        stall_o;
    logic [31:0] result_o, pc_o;
    logic [1:0]  reg_write_o, exc_cause_o;
    logic [63:0] ir_o;
    logic        exc_o;
    int          total = 0;
    int          bad = 0;

    mem_access_if bus_if ();

    mem_access #(.TIMEOUT(TMO)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .ir_i        (ir_i),
        .pc_i        (pc_i),
        .result_i    (result_i),
        .reg_data1_i (reg_data1_i),
        .reg_write_i (reg_write_i),
        .stall_o     (stall_o),
        .bus         (bus_if),
        .result_o    (result_o),
        .reg_write_o (reg_write_o),
        .ir_o        (ir_o),
        .pc_o        (pc_o),
        .exc_o       (exc_o),
        .exc_cause_o (exc_cause_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
        end
    endtask

    function automatic vec_t model(input vec_t v);
        vec_t        e;
        int          bytes;
        int          a;
        logic [63:0] mask;
        logic        load;
        e = v;
        a = int'(v.adr[1:0]);
        bytes = (v.sz == 2'd1) ? 2 : (v.sz == 2'd2) ? 1 : 4;
        e.e_sel = '0;
        e.e_dat = '0;
        e.e_cause = 2'd0;
        if (v.typ != T_LOAD && v.typ != T_STORE) begin
            e.e_res = v.adr;
            e.e_rw = v.rwi;
            return e;
        end
        load = (v.typ == T_LOAD);
        e.e_res = '0;
        e.e_rw = 2'd0;
        if (a % bytes != 0) begin
            e.e_cause = 2'd1;
            return e;
        end
        mask = (64'd1 << (8 * bytes)) - 64'd1;
        e.e_sel = 4'(((1 << bytes) - 1) << (4 - a - bytes));
        for (int i = 0; i < 4 / bytes; i++)
            e.e_dat = e.e_dat | 32'((64'(v.sdata) & mask) << (8 * bytes * i));
        case (v.kind)
            0: begin
                e.e_res = load ? 32'((64'(v.rdata) >> (8 * (4 - a - bytes))) & mask) : v.adr;
                e.e_rw = load ? 2'd3 : 2'd0;
            end
            1, 3: e.e_cause = 2'd2;
            default: e.e_cause = 2'd3;
        endcase
        return e;
    endfunction

    // Entered and left just after a falling edge.
    task automatic do_op(input vec_t v, input vec_t e, input int idx);
        logic [63:0] ir;
        logic [31:0] pc;
        logic        mem;
        int          limit;
        int          cyc_n;
        ir = {32'($urandom()), v.typ, 2'($urandom_range(0, 3)), v.sz, 24'($urandom())};
        pc = $urandom();
        ir_i = ir;
        pc_i = pc;
        result_i = v.adr;
        reg_data1_i = v.sdata;
        reg_write_i = v.rwi;
        bus_if.ack = 1'b0;
        bus_if.err = 1'b0;
        bus_if.dat_r = v.rdata;
        mem = (v.typ == T_LOAD || v.typ == T_STORE);
        #1;
        if (!mem || e.e_cause == 2'd1) begin
            chk("stall_low", idx, stall_o, 1'b0);
            @(posedge clk);
            @(negedge clk);
            chk("no_cyc", idx, bus_if.cyc, 1'b0);
            if (!mem) begin
                chk("pass_ir", idx, ir_o, ir);
                chk("pass_pc", idx, pc_o, pc);
                chk("pass_res", idx, result_o, e.e_res);
                chk("pass_rw", idx, reg_write_o, e.e_rw);
                chk("pass_exc", idx, exc_o, 1'b0);
            end else begin
                chk("mis_exc", idx, exc_o, 1'b1);
                chk("mis_cause", idx, exc_cause_o, 2'd1);
                chk("mis_ir", idx, ir_o, 64'd0);
                chk("mis_rw", idx, reg_write_o, 2'd0);
            end
            return;
        end
        chk("issue_stall", idx, stall_o, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("cyc_stb", idx, {bus_if.cyc, bus_if.stb}, 2'b11);
        chk("adr", idx, bus_if.adr, v.adr);
        chk("sel", idx, bus_if.sel, e.e_sel);
        chk("we", idx, bus_if.we, (v.typ == T_STORE));
        if (v.typ == T_STORE) chk("dat_w", idx, bus_if.dat_w, e.e_dat);
        limit = (v.kind == 2) ? TMO : v.waits;
        cyc_n = 0;
        for (int k = 0; k <= limit; k++) begin
            bus_if.ack = (k == limit) && (v.kind == 0 || v.kind == 3);
            bus_if.err = (k == limit) && (v.kind == 1 || v.kind == 3);
            if (bus_if.cyc === 1'b1) cyc_n++;
            #1;
            if (k == 0 || k == limit) chk("bus_stall", idx, stall_o, (k != limit));
            if (k == limit) chk("bubble", idx, {ir_o, reg_write_o}, 66'd0);
            @(posedge clk);
            @(negedge clk);
        end
        bus_if.ack = 1'b0;
        bus_if.err = 1'b0;
        chk("cyc_cycles", idx, cyc_n, limit + 1);
        chk("cyc_drop", idx, {bus_if.cyc, bus_if.stb}, 2'b00);
        chk("exc", idx, exc_o, (e.e_cause != 2'd0));
        chk("cause", idx, exc_cause_o, e.e_cause);
        chk("wb_rw", idx, reg_write_o, e.e_rw);
        if (e.e_cause == 2'd0) begin
            chk("wb_res", idx, result_o, e.e_res);
            chk("wb_ir", idx, ir_o, ir);
            chk("wb_pc", idx, pc_o, pc);
        end else begin
            chk("fault_ir", idx, ir_o, 64'd0);
        end
    endtask

    vec_t tbl[15];
    logic [3:0] typs[5];
    vec_t rv;

    initial begin
        tbl[0]  = '{T_ALU,   2'd0, 2'd1, 32'h12345678, 32'h0,        32'h0,        0, 0, 4'h0,    32'h0,        32'h12345678, 2'd1, 2'd0};
        tbl[1]  = '{T_LOAD,  2'd0, 2'd0, 32'h00001000, 32'h0,        32'hDEADBEEF, 2, 0, 4'hF,    32'h0,        32'hDEADBEEF, 2'd3, 2'd0};
        tbl[2]  = '{T_LOAD,  2'd2, 2'd0, 32'h00001002, 32'h0,        32'hAABBCCDD, 0, 0, 4'b0010, 32'h0,        32'h000000CC, 2'd3, 2'd0};
        tbl[3]  = '{T_STORE, 2'd1, 2'd0, 32'h00002002, 32'h0000BEEF, 32'h0,        1, 0, 4'b0011, 32'hBEEFBEEF, 32'h00002002, 2'd0, 2'd0};
        tbl[4]  = '{T_LOAD,  2'd0, 2'd0, 32'h00001001, 32'h0,        32'h0,        0, 0, 4'h0,    32'h0,        32'h0,        2'd0, 2'd1};
        tbl[5]  = '{T_ALU,   2'd0, 2'd2, 32'h55AA00FF, 32'h0,        32'h0,        0, 0, 4'h0,    32'h0,        32'h55AA00FF, 2'd2, 2'd0};
        tbl[6]  = '{T_LOAD,  2'd1, 2'd0, 32'h00003001, 32'h0,        32'h0,        0, 0, 4'h0,    32'h0,        32'h0,        2'd0, 2'd1};
        tbl[7]  = '{T_STORE, 2'd2, 2'd0, 32'h00004003, 32'h12345A7C, 32'h0,        0, 0, 4'b0001, 32'h7C7C7C7C, 32'h00004003, 2'd0, 2'd0};
        tbl[8]  = '{T_LOAD,  2'd0, 2'd0, 32'h00005000, 32'h0,        32'h11111111, 1, 1, 4'hF,    32'h0,        32'h0,        2'd0, 2'd2};
        tbl[9]  = '{T_STORE, 2'd0, 2'd0, 32'h00005004, 32'h13572468, 32'h0,        0, 3, 4'hF,    32'h13572468, 32'h0,        2'd0, 2'd2};
        tbl[10] = '{T_LOAD,  2'd0, 2'd0, 32'h00006000, 32'h0,        32'h0,        0, 2, 4'hF,    32'h0,        32'h0,        2'd0, 2'd3};
        tbl[11] = '{T_LOAD,  2'd1, 2'd0, 32'h00001000, 32'h0,        32'hCAFE1234, 3, 0, 4'b1100, 32'h0,        32'h0000CAFE, 2'd3, 2'd0};
        tbl[12] = '{T_LOAD,  2'd3, 2'd0, 32'h00007004, 32'h0,        32'h01020304, 0, 0, 4'hF,    32'h0,        32'h01020304, 2'd3, 2'd0};
        tbl[13] = '{T_LOAD,  2'd2, 2'd0, 32'h00001001, 32'h0,        32'hAABBCCDD, 1, 0, 4'b0100, 32'h0,        32'h000000BB, 2'd3, 2'd0};
        tbl[14] = '{T_STORE, 2'd0, 2'd0, 32'h00008000, 32'hA5A5F00F, 32'h0,        0, 0, 4'hF,    32'hA5A5F00F, 32'h00008000, 2'd0, 2'd0};
        typs = '{T_ALU, T_LOAD, T_STORE, 4'h0, 4'hC};

        rst_i = 1'b1;
        ir_i = {32'h0, T_LOAD, 4'h0, 24'h0};
        pc_i = '0;
        result_i = 32'h1000;
        reg_data1_i = '0;
        reg_write_i = 2'd3;
        bus_if.ack = 1'b0;
        bus_if.err = 1'b0;
        bus_if.dat_r = '0;
        repeat (2) @(negedge clk);
        chk("rst_stall", 0, stall_o, 1'b0);
        chk("rst_bus", 0, {bus_if.cyc, bus_if.stb, bus_if.we, bus_if.sel}, 7'd0);
        chk("rst_wb", 0, {result_o, reg_write_o, ir_o, pc_o}, 130'd0);
        chk("rst_exc", 0, {exc_o, exc_cause_o}, 3'd0);
        ir_i = '0;
        rst_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) do_op(tbl[i], tbl[i], i);

        // Reset while a bus cycle is open; the ack that follows must not write back.
        ir_i = {32'h0, T_LOAD, 4'h0, 24'h0};
        result_i = 32'h9000;
        bus_if.dat_r = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        chk("rmid_open", 0, bus_if.cyc, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        chk("rmid_drop", 0, {bus_if.cyc, bus_if.stb}, 2'b00);
        chk("rmid_stall", 0, stall_o, 1'b0);
        @(negedge clk);
        rst_i = 1'b0;
        bus_if.ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rmid_no_wb", 0, {reg_write_o, ir_o}, 66'd0);
        chk("rmid_no_exc", 0, exc_o, 1'b0);
        bus_if.ack = 1'b0;
        ir_i = '0;
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            int r;
            rv.typ = typs[$urandom_range(0, 4)];
            rv.sz = 2'($urandom_range(0, 3));
            rv.rwi = 2'($urandom_range(0, 3));
            rv.adr = $urandom();
            rv.sdata = $urandom();
            rv.rdata = $urandom();
            rv.waits = $urandom_range(0, 3);
            r = $urandom_range(0, 39);
            rv.kind = (r < 32) ? 0 : (r < 37) ? 1 : (r < 39) ? 3 : 2;
            do_op(rv, model(rv), 100 + n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk_i  in  1  clock; all state on rising edge.
REQ-002 rst_i  in  1  reset, asynchronous, active-high.
REQ-003 ir_i  in  64  instruction from execute; [31:28] type, [27:24] op, [63:32] extension word.
REQ-004 pc_i  in  32  instruction PC from execute.
REQ-005 result_i  in  32  execute result; effective address for T_LOAD/T_STORE.
REQ-006 reg_data1_i  in  32  store data.
REQ-007 reg_write_i  in  2  register-write enables from execute.
REQ-008 stall_o  out  1  combinational; upstream holds ir_i/pc_i/result_i/reg_data1_i/reg_write_i while high.
REQ-009 bus_cyc_o, bus_stb_o, bus_we_o  out  1 each  Wishbone classic controls.
REQ-010 bus_adr_o  out  32  word address, byte granular; bus_sel_o  out  4  byte lanes, [3] = adr[1:0]==0 (big-endian).
REQ-011 bus_dat_o  out  32; bus_dat_i  in  32; bus_ack_i, bus_err_i  in  1.
REQ-012 result_o  out  32; reg_write_o  out  2; ir_o  out  64; pc_o  out  32 -- to writeback.
REQ-013 exc_o  out  1  one-cycle pulse; exc_cause_o  out  2  (0 none, 1 misalign, 2 bus error, 3 timeout).
REQ-014 Parameter TIMEOUT, default 255, bus wait cycles before abort.

Function
REQ-015 Size from ir_op[1:0]: 0 word, 1 half, 2 byte, 3 reserved (treated as word).
REQ-016 Non-memory types: ir_o/pc_o/result_o/reg_write_o register ir_i/pc_i/result_i/reg_write_i; latency 1; stall_o low.
REQ-017 FSM states S_IDLE, S_BUS.
REQ-018 S_IDLE, memory op, aligned: stall_o=1; bus_adr_o/bus_sel_o/bus_we_o/bus_dat_o registered; cyc=stb=1 next cycle; -> S_BUS; writeback outputs bubble (ir_o=0, reg_write_o=0).
REQ-019 S_BUS: stall_o = !(bus_ack_i|bus_err_i|timeout); counter increments each cycle without ack.
REQ-020 Ack in S_BUS: cyc/stb drop next edge; load: result_o = lane-extracted, zero-extended data, reg_write_o=2'b11; store: result_o=result_i, reg_write_o=0; ir_o/pc_o pass through; -> S_IDLE.
REQ-021 Store data replicated: half = {d[15:0],d[15:0]}, byte = 4x d[7:0]; sel from size and adr[1:0].
REQ-022 Minimum memory-op latency 2 cycles (zero-wait ack); each wait cycle adds 1.
REQ-023 Misaligned (half adr[0]=1; word adr[1:0]!=0): no bus cycle, stall_o low, bubble, exc_o pulse, cause 1.
REQ-024 bus_err_i in S_BUS: end cycle as ack, bubble, cause 2; err has priority over simultaneous ack.
REQ-025 Counter reaching TIMEOUT: drop cyc/stb, bubble, cause 3, -> S_IDLE.
REQ-026 Back-to-back memory ops: next issue detected in the cycle after completion; no overlapping cycles.

Reset
REQ-027 Reset forces S_IDLE, counter 0, all outputs 0 (bus_sel_o=0, exc_cause_o=0).
REQ-028 Reset mid-transaction drops bus_cyc_o/bus_stb_o immediately; late ack after reset ignored.

Structure
REQ-029 T_LOAD, T_STORE, size codes, exception-cause codes belong in bexkat1Def package.
REQ-030 Lane steering (sel, store replicate, load extract) in combinational sub-module mem_lane.

Verification
REQ-031 Non-mem ALU: ir_i type T_ALU, result_i=0x12345678 -> result_o=0x12345678 next edge, stall_o low throughout.
REQ-032 Word load adr 0x1000, ack after 2 waits, dat_i=0xDEADBEEF -> cyc high 3 cycles, result_o=0xDEADBEEF, reg_write_o=3, total latency 4.
REQ-033 Byte load adr 0x1002, dat_i=0xAABBCCDD -> sel=4'b0010, result_o=0x000000CC.
REQ-034 Half store adr 0x2002, reg_data1_i=0x0000BEEF -> we=1, sel=4'b0011, dat_o=0xBEEFBEEF, reg_write_o=0.
REQ-035 Word load adr 0x1001 -> no cyc, exc_o pulse cause 1; no ack for TIMEOUT cycles -> cause 3, cyc dropped.
REQ-036 rst_i asserted during S_BUS -> cyc/stb low same cycle; ack next cycle produces no writeback.
